// File: rtl/ins_fetch_pkg.sv
// Shared types for the instruction prefetch unit: fetch FSM states and the
// buffered {ins, npc} entry layout.
package ins_fetch_pkg;

   // Width of the default entry; matches the default BUS_WIDTH of the unit.
   localparam int unsigned FETCH_WIDTH = 32;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDrain
   } fetch_state_t;

   typedef struct packed {
      logic [FETCH_WIDTH-1:0] ins;
      logic [FETCH_WIDTH-1:0] npc;
   } fetch_entry_t;

endpackage

// File: rtl/ins_fifo.sv
// DEPTH-entry synchronous FIFO with a flush input. Flush wins over push and
// pop in the same cycle. Storage is not reset; consumers qualify head_out with
// empty_out.
module ins_fifo
   import ins_fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = fetch_entry_t,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n_in,
   input  logic             flush_in,
   input  logic             push_in,
   input  entry_t           push_data_in,
   input  logic             pop_in,
   output entry_t           head_out,
   output logic             empty_out,
   output logic [CNT_W-1:0] count_out
);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   // Pointer and occupancy update; DEPTH is a power of two so pointers wrap.
   always_ff @(posedge clock or negedge reset_n_in) begin
      if (!reset_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_in) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_in)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push_in && !pop_in) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop_in && !push_in) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   // Entry storage write.
   always_ff @(posedge clock) begin
      if (push_in && !flush_in) mem_q[wr_ptr_q] <= push_data_in;
   end

   assign head_out  = mem_q[rd_ptr_q];
   assign empty_out = (count_q == '0);
   assign count_out = count_q;

endmodule

// File: rtl/ins_prefetch_unit.sv
// Instruction prefetch unit: keeps up to DEPTH fetched instructions ahead of
// decode, with at most one memory read outstanding. Space is reserved before a
// request is issued, so a response never lands in a full buffer.
// Optional feature: define INS_PREFETCH_BYPASS_EN to present a response that
// arrives at an empty buffer in the same cycle.
module ins_prefetch_unit
   import ins_fetch_pkg::*;
#(
   parameter int unsigned          BUS_WIDTH    = 32,
   parameter int unsigned          DEPTH        = 4,
   parameter logic [BUS_WIDTH-1:0] PC_INCREMENT = BUS_WIDTH'(1),
   parameter logic [BUS_WIDTH-1:0] RESET_PC     = '0,
   localparam int unsigned         CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic                 clock,
   input  logic                 reset_n_in,
   input  logic                 redirect_valid_in,
   input  logic [BUS_WIDTH-1:0] redirect_pc_in,
   output logic                 mem_req_out,
   output logic [BUS_WIDTH-1:0] mem_addr_out,
   input  logic                 mem_gnt_in,
   input  logic                 mem_rvalid_in,
   input  logic [BUS_WIDTH-1:0] mem_rdata_in,
   output logic                 ins_valid_out,
   input  logic                 ins_ready_in,
   output logic [BUS_WIDTH-1:0] ins_out,
   output logic [BUS_WIDTH-1:0] npc_out,
   output logic [CNT_W-1:0]     count_out
);

   // Same layout as fetch_entry_t, sized to BUS_WIDTH.
   typedef struct packed {
      logic [BUS_WIDTH-1:0] ins;
      logic [BUS_WIDTH-1:0] npc;
   } entry_t;

   localparam logic [CNT_W:0] DEPTH_CNT = (CNT_W + 1)'(DEPTH);

   fetch_state_t         state_q;
   logic [BUS_WIDTH-1:0] fetch_pc_q;

   entry_t           fifo_head;
   entry_t           rsp_entry;
   entry_t           head;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             rsp_accept;
   logic             bypass_hit;
   logic             head_valid;
   logic             pop;
   logic             fifo_push;
   logic             fifo_pop;
   logic [CNT_W:0]   count_after_pop;
   logic [CNT_W:0]   count_after_rsp;

   // Response acceptance, bypass, push/pop and post-update occupancy.
   always_comb begin
      rsp_accept    = (state_q == StWait) && mem_rvalid_in && !redirect_valid_in;
      // In WAIT fetch_pc_q already holds issued address + PC_INCREMENT.
      rsp_entry.ins = mem_rdata_in;
      rsp_entry.npc = fetch_pc_q;
`ifdef INS_PREFETCH_BYPASS_EN
      bypass_hit    = rsp_accept && fifo_empty;
`else
      bypass_hit    = 1'b0;
`endif
      head_valid      = !fifo_empty || bypass_hit;
      head            = fifo_empty ? rsp_entry : fifo_head;
      pop             = head_valid && ins_ready_in;
      fifo_pop        = pop && !fifo_empty && !redirect_valid_in;
      // A bypassed response taken by decode this cycle is never stored.
      fifo_push       = rsp_accept && !(bypass_hit && ins_ready_in);
      count_after_pop = {1'b0, fifo_count} - {{CNT_W{1'b0}}, fifo_pop};
      count_after_rsp = count_after_pop + {{CNT_W{1'b0}}, fifo_push};
   end

   // Fetch FSM and fetch address; redirect takes priority over everything.
   always_ff @(posedge clock or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
      end else begin
         if (redirect_valid_in) begin
            fetch_pc_q <= redirect_pc_in;
         end else if ((state_q == StReq) && mem_gnt_in) begin
            fetch_pc_q <= fetch_pc_q + PC_INCREMENT;
         end

         unique case (state_q)
            StIdle: begin
               if (redirect_valid_in || (count_after_pop < DEPTH_CNT)) state_q <= StReq;
            end
            StReq: begin
               // A grant alongside a redirect leaves a response to throw away.
               if (mem_gnt_in) state_q <= redirect_valid_in ? StDrain : StWait;
            end
            StWait: begin
               if (redirect_valid_in) begin
                  state_q <= mem_rvalid_in ? StReq : StDrain;
               end else if (mem_rvalid_in) begin
                  state_q <= (count_after_rsp < DEPTH_CNT) ? StReq : StIdle;
               end
            end
            StDrain: begin
               // The stale response completes the drain even if a new redirect
               // arrives with it; otherwise a redirect keeps waiting here.
               if (mem_rvalid_in) state_q <= StReq;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   ins_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clock        (clock),
      .reset_n_in   (reset_n_in),
      .flush_in     (redirect_valid_in),
      .push_in      (fifo_push),
      .push_data_in (rsp_entry),
      .pop_in       (fifo_pop),
      .head_out     (fifo_head),
      .empty_out    (fifo_empty),
      .count_out    (fifo_count)
   );

   assign mem_req_out   = (state_q == StReq);
   assign mem_addr_out  = mem_req_out ? fetch_pc_q : '0;
   assign ins_valid_out = head_valid;
   assign ins_out       = head_valid ? head.ins : '0;
   assign npc_out       = head_valid ? head.npc : '0;
   assign count_out     = fifo_count;

endmodule

// File: tb/tb_ins_prefetch_unit.sv
// Scoreboard bench for ins_prefetch_unit: expected request addresses and
// expected {ins, npc} handshakes are queued by the stimulus and checked by
// independent monitors. A second instance covers RESET_PC = 0xFFFFFFFF.
module tb_ins_prefetch_unit;

`ifdef INS_PREFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n_in = 1'b0;
   logic        redirect_valid_in = 1'b0;
   logic [31:0] redirect_pc_in = '0;
   logic        mem_req_out;
   logic [31:0] mem_addr_out;
   logic        mem_gnt_in = 1'b0;
   logic        mem_rvalid_in = 1'b0;
   logic [31:0] mem_rdata_in = '0;
   logic        ins_valid_out;
   logic        ins_ready_in = 1'b0;
   logic [31:0] ins_out;
   logic [31:0] npc_out;
   logic [2:0]  count_out;

   // Second instance, driven directly.
   logic        b_req;
   logic [31:0] b_addr;
   logic        b_gnt = 1'b0;
   logic        b_rvalid = 1'b0;
   logic [31:0] b_rdata = '0;
   logic        b_valid;
   logic [31:0] b_ins;
   logic [31:0] b_npc;
   logic [2:0]  b_count;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_addr[$];
   logic [63:0] exp_ins[$];

   // Memory model controls.
   int          grants_left = 0;
   int          latency = 1;
   int          total_grants = 0;
   bit          pending = 1'b0;
   int          lat_cnt = 0;
   logic [31:0] gaddr = '0;
   logic [31:0] paddr = '0;

   always #5 clock = ~clock;

   ins_prefetch_unit #(
      .BUS_WIDTH    (32),
      .DEPTH        (4),
      .PC_INCREMENT (32'd1),
      .RESET_PC     (32'd0)
   ) dut (
      .clock             (clock),
      .reset_n_in        (reset_n_in),
      .redirect_valid_in (redirect_valid_in),
      .redirect_pc_in    (redirect_pc_in),
      .mem_req_out       (mem_req_out),
      .mem_addr_out      (mem_addr_out),
      .mem_gnt_in        (mem_gnt_in),
      .mem_rvalid_in     (mem_rvalid_in),
      .mem_rdata_in      (mem_rdata_in),
      .ins_valid_out     (ins_valid_out),
      .ins_ready_in      (ins_ready_in),
      .ins_out           (ins_out),
      .npc_out           (npc_out),
      .count_out         (count_out)
   );

   ins_prefetch_unit #(
      .BUS_WIDTH    (32),
      .DEPTH        (4),
      .PC_INCREMENT (32'd1),
      .RESET_PC     (32'hFFFF_FFFF)
   ) dut_b (
      .clock             (clock),
      .reset_n_in        (reset_n_in),
      .redirect_valid_in (1'b0),
      .redirect_pc_in    (32'd0),
      .mem_req_out       (b_req),
      .mem_addr_out      (b_addr),
      .mem_gnt_in        (b_gnt),
      .mem_rvalid_in     (b_rvalid),
      .mem_rdata_in      (b_rdata),
      .ins_valid_out     (b_valid),
      .ins_ready_in      (1'b1),
      .ins_out           (b_ins),
      .npc_out           (b_npc),
      .count_out         (b_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s", name);
   endtask

   // Memory model: grants one request at a time, responds after 'latency' cycles
   // with data = addr ^ 0x5A5A0000. Drives at posedge+2.
   initial begin
      forever begin
         @(posedge clock);
         #2;
         if (!reset_n_in) begin
            pending       = 1'b0;
            mem_gnt_in    = 1'b0;
            mem_rvalid_in = 1'b0;
         end else begin
            mem_rvalid_in = 1'b0;
            if (mem_gnt_in) begin
               mem_gnt_in = 1'b0;
               pending    = 1'b1;
               lat_cnt    = latency;
               paddr      = gaddr;
            end
            if (pending) begin
               if (lat_cnt <= 1) begin
                  mem_rvalid_in = 1'b1;
                  mem_rdata_in  = paddr ^ 32'h5A5A_0000;
                  pending       = 1'b0;
               end else begin
                  lat_cnt--;
               end
            end
            if (!pending && mem_req_out && grants_left > 0) begin
               mem_gnt_in = 1'b1;
               gaddr      = mem_addr_out;
               grants_left--;
               total_grants++;
            end
         end
      end
   end

   // Request-address monitor.
   initial begin
      forever begin
         @(negedge clock);
         if (reset_n_in && mem_req_out && mem_gnt_in) begin
            if (exp_addr.size() == 0) fail($sformatf("unexpected request to 0x%08h", mem_addr_out));
            else check("request addr", mem_addr_out, exp_addr.pop_front());
         end
      end
   end

   // Instruction handshake monitor.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clock);
         if (reset_n_in && ins_valid_out && ins_ready_in) begin
            if (exp_ins.size() == 0) begin
               fail($sformatf("unexpected ins 0x%08h npc 0x%08h", ins_out, npc_out));
            end else begin
               e = exp_ins.pop_front();
               check("ins_out", ins_out, e[63:32]);
               check("npc_out", npc_out, e[31:0]);
            end
         end
      end
   end

   task automatic do_reset(input int lat, input int grants, input logic rdy);
      @(posedge clock);
      #1;
      reset_n_in        = 1'b0;
      redirect_valid_in = 1'b0;
      ins_ready_in      = 1'b0;
      grants_left       = 0;
      repeat (2) @(posedge clock);
      #1;
      latency      = lat;
      grants_left  = grants;
      total_grants = 0;
      ins_ready_in = rdy;
      reset_n_in   = 1'b1;
   endtask

   task automatic wait_grant(input string name);
      int g = 0;
      do begin
         @(negedge clock);
         g++;
      end while (!(mem_req_out && mem_gnt_in) && g < 50);
      if (!(mem_req_out && mem_gnt_in)) fail({name, " grant timeout"});
   endtask

   task automatic check_drained(input string name);
      check({name, " addr queue left"}, exp_addr.size(), 0);
      check({name, " ins queue left"}, exp_ins.size(), 0);
   endtask

   initial begin
      int g;
      // Reset values apply before any clock edge.
      #3;
      check("rst mem_req_out", mem_req_out, 0);
      check("rst mem_addr_out", mem_addr_out, 0);
      check("rst ins_valid_out", ins_valid_out, 0);
      check("rst ins_out", ins_out, 0);
      check("rst npc_out", npc_out, 0);
      check("rst count_out", count_out, 0);

      // T1: one-cycle memory, decode always ready.
      exp_addr = '{32'd0, 32'd1, 32'd2, 32'd3};
      exp_ins  = '{{32'h5A5A_0000, 32'd1}, {32'h5A5A_0001, 32'd2},
                   {32'h5A5A_0002, 32'd3}, {32'h5A5A_0003, 32'd4}};
      do_reset(1, 4, 1'b1);
      repeat (25) @(posedge clock);
      check_drained("t1");

      // T2: stalled decode fills exactly DEPTH entries.
      exp_addr = '{32'd0, 32'd1, 32'd2, 32'd3};
      do_reset(1, 100, 1'b0);
      repeat (25) @(posedge clock);
      @(negedge clock);
      check("t2 grants when full", total_grants, 4);
      check("t2 count full", count_out, 4);
      check("t2 req idle when full", mem_req_out, 0);
      check("t2 valid when full", ins_valid_out, 1);
      exp_ins.push_back({32'h5A5A_0000, 32'd1});
      exp_addr.push_back(32'd4);
      @(posedge clock);
      #1;
      ins_ready_in = 1'b1;
      @(posedge clock);
      #1;
      ins_ready_in = 1'b0;
      repeat (10) @(posedge clock);
      @(negedge clock);
      check("t2 grants after pop", total_grants, 5);
      check("t2 count refilled", count_out, 4);
      check("t2 req idle again", mem_req_out, 0);
      check_drained("t2");
      // Asynchronous reset while full.
      @(posedge clock);
      #1;
      reset_n_in = 1'b0;
      #1;
      check("t2 async count", count_out, 0);
      check("t2 async valid", ins_valid_out, 0);
      check("t2 async ins", ins_out, 0);

      // T3: redirect in WAIT, stale response 3 cycles later.
      exp_addr = '{32'd0};
      do_reset(4, 1, 1'b1);
      wait_grant("t3");
      @(posedge clock);
      #1;
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 32'h100;
      exp_addr.push_back(32'h100);
      exp_ins.push_back({32'h5A5A_0100, 32'h101});
      grants_left = 1;
      @(posedge clock);
      #1;
      redirect_valid_in = 1'b0;
      @(negedge clock);
      check("t3 count after redirect", count_out, 0);
      check("t3 valid after redirect", ins_valid_out, 0);
      check("t3 no req while draining", mem_req_out, 0);
      repeat (25) @(posedge clock);
      check_drained("t3");

      // T4: redirect together with pop and response.
      exp_addr = '{32'd0, 32'd1};
      do_reset(1, 2, 1'b0);
      repeat (12) @(posedge clock);
      #1;
      latency = 3;
      grants_left = 1;
      exp_addr.push_back(32'd2);
      wait_grant("t4");
      repeat (3) @(posedge clock);
      #1;
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 32'h200;
      ins_ready_in      = 1'b1;
      exp_ins.push_back({32'h5A5A_0000, 32'd1});
      exp_ins.push_back({32'h5A5A_0200, 32'h201});
      exp_addr.push_back(32'h200);
      grants_left = 1;
      @(negedge clock);
      check("t4 count before redirect", count_out, 2);
      if (!mem_rvalid_in) fail("t4 response not aligned with redirect");
      @(posedge clock);
      #1;
      redirect_valid_in = 1'b0;
      @(negedge clock);
      check("t4 count after redirect", count_out, 0);
      check("t4 valid after redirect", ins_valid_out, 0);
      repeat (20) @(posedge clock);
      check_drained("t4");

      // T5: response timing into an empty buffer.
      exp_addr = '{32'd0};
      exp_ins  = '{{32'h5A5A_0000, 32'd1}};
      do_reset(1, 1, 1'b1);
      g = 0;
      do begin
         @(negedge clock);
         g++;
      end while (!mem_rvalid_in && g < 30);
      if (!mem_rvalid_in) begin
         fail("t5 rvalid timeout");
      end else begin
         check("t5 valid with rvalid", ins_valid_out, BYP);
         @(negedge clock);
         check("t5 valid cycle after", ins_valid_out, !BYP);
      end
      repeat (5) @(posedge clock);
      check_drained("t5");

      // T6: RESET_PC = 0xFFFFFFFF wraps.
      do_reset(1, 0, 1'b0);
      g = 0;
      do begin
         @(negedge clock);
         g++;
      end while (!b_req && g < 20);
      check("t6 first addr", b_addr, 32'hFFFF_FFFF);
      @(posedge clock);
      #1;
      b_gnt = 1'b1;
      @(posedge clock);
      #1;
      b_gnt    = 1'b0;
      b_rvalid = 1'b1;
      b_rdata  = 32'hDEAD_0001;
      @(negedge clock);
      if (!b_valid) begin
         @(posedge clock);
         #1;
         b_rvalid = 1'b0;
         @(negedge clock);
      end
      check("t6 valid", b_valid, 1);
      check("t6 ins", b_ins, 32'hDEAD_0001);
      check("t6 npc wraps", b_npc, 32'd0);
      @(posedge clock);
      #1;
      b_rvalid = 1'b0;
      g = 0;
      do begin
         @(negedge clock);
         g++;
      end while (!b_req && g < 20);
      check("t6 second req", b_req, 1);
      check("t6 second addr", b_addr, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
